// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset vector default, instruction lengths and the RVC opcode test.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ILEN16           = 32'd2;
  localparam logic [31:0] ILEN32           = 32'd4;

  // RVC encodings use any quadrant except 2'b11 in the low opcode bits
  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/ack side, redirect, and decode handshake.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic [31:0]      mem_data;
  logic             br_en;
  logic [31:0]      br_addr;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_ir;
  logic [31:0]      id_pc;
  logic [31:0]      id_ret;
  logic             hz_br;
  logic [CNT_W-1:0] count;

  modport master (
    output mem_req, mem_addr, id_valid, id_ir, id_pc, id_ret, hz_br, count,
    input  mem_ack, mem_data, br_en, br_addr, id_ready
  );

  modport slave (
    input  mem_req, mem_addr, id_valid, id_ir, id_pc, id_ret, hz_br, count,
    output mem_ack, mem_data, br_en, br_addr, id_ready
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush, exposing the head and head+1 entries.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           head1,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot the same-cycle push needs, so push is legal when full too
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (ce) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ce && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue with branch redirect; define FETCH_COMPRESSED_EN for RVC alignment.
module fetch_queue
  import cpu_defs::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clk_ce,
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem_addr;
  logic [CNT_W-1:0] count;
  logic [63:0]      head;
  logic [63:0]      head1;
  logic [31:0]      w0;
  logic [31:0]      a0;
  logic             push;
  logic             pop;
  logic             xfer;
  logic             valid;
  logic [31:0]      ir;
  logic [31:0]      pc;
  logic [31:0]      ret;
  logic             unused_bits;

  assign w0 = head[63:32];
  assign a0 = head[31:0];

  assign bus.mem_req = i_rst_n && (count < CNT_W'(DEPTH)) && !bus.br_en;
  assign push        = i_clk_ce && bus.mem_req && bus.mem_ack;
  assign xfer        = i_clk_ce && valid && bus.id_ready && !bus.br_en;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .ce        (i_clk_ce),
    .flush     (bus.br_en),
    .push      (push),
    .push_data ({bus.mem_data, mem_addr}),
    .pop       (pop),
    .head      (head),
    .head1     (head1),
    .count     (count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_addr <= {RESET_PC[31:2], 2'b00};
    end else if (i_clk_ce) begin
      if (bus.br_en)  mem_addr <= {bus.br_addr[31:2], 2'b00};
      else if (push)  mem_addr <= mem_addr + ILEN32;
    end
  end

`ifdef FETCH_COMPRESSED_EN
  logic [31:0] w1;
  logic        half_off;
  logic        is16;

  assign w1 = head1[63:32];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      half_off <= RESET_PC[1];
    end else if (i_clk_ce) begin
      if (bus.br_en)         half_off <= bus.br_addr[1];
      else if (xfer && is16) half_off <= !half_off;
    end
  end

  // A 32-bit opcode straddling two words needs the next entry before it is valid
  always_comb begin
    ir    = w0;
    pc    = a0;
    ret   = a0 + ILEN32;
    is16  = 1'b0;
    valid = (count != '0);
    if (!half_off) begin
      if (is_compressed(w0[15:0])) begin
        ir   = {16'h0000, w0[15:0]};
        ret  = a0 + ILEN16;
        is16 = 1'b1;
      end
    end else begin
      pc = a0 + ILEN16;
      if (is_compressed(w0[31:16])) begin
        ir   = {16'h0000, w0[31:16]};
        ret  = a0 + ILEN32;
        is16 = 1'b1;
      end else begin
        ir    = {w1[15:0], w0[31:16]};
        ret   = a0 + ILEN16 + ILEN32;
        valid = (count >= CNT_W'(2));
      end
    end
  end

  // Only a 16-bit opcode in the low half stays inside the head word
  assign pop         = xfer && !(is16 && !half_off);
  assign unused_bits = ^{bus.br_addr[0], head1[31:0]};
`else
  always_comb begin
    valid = (count != '0);
    ir    = w0;
    pc    = a0;
    ret   = a0 + ILEN32;
  end

  assign pop         = xfer;
  assign unused_bits = ^{bus.br_addr[1:0], head1};
`endif

  assign bus.mem_addr = mem_addr;
  assign bus.count    = count;
  assign bus.id_valid = valid;
  assign bus.hz_br    = !valid;
  assign bus.id_ir    = valid ? ir  : 32'h0;
  assign bus.id_pc    = valid ? pc  : 32'h0;
  assign bus.id_ret   = valid ? ret : 32'h0;

endmodule
